// File: rtl/bcd_entry_pkg.sv
// Shared definitions for the decimal operand-entry block.
//   state_t        : entry FSM states
//   WIDTH_DEF      : default binary operand width
//   MAX_DIGITS_DEF : default maximum digits per entry
//   DIGIT_MAX      : largest legal BCD digit
package bcd_entry_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam int unsigned WIDTH_DEF      = 18;
  localparam int unsigned MAX_DIGITS_DEF = 6;
  localparam logic [3:0]  DIGIT_MAX      = 4'd9;

endpackage

// File: rtl/bcd_entry_push_sync.sv
// Pushbutton synchronizer and falling-edge detector.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (flops reset to released level 1)
//   push_n : raw active-low button, asynchronous to clk
//   press  : one-cycle pulse per falling edge of push_n
// Debouncing is expected upstream. press is decoded from flops only, so a
// consumer that registers on it updates on the 3rd edge after push_n is
// first sampled low.
module push_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic push_n,
  output logic press
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= push_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press = s3 & ~s2;

endmodule

// File: rtl/bcd_entry.sv
// Decimal operand entry: accumulates keyed BCD digits into a binary operand
// (value = value*10 + digit) and mirrors the typed digits as packed BCD.
//   clk, rst_n : clock, asynchronous active-low reset
//   digit      : BCD digit, sampled on a detected press
//   push_n     : raw active-low digit button
//   commit     : single-cycle pulse ending the entry
//   clear      : single-cycle pulse abandoning the entry
//   value      : accumulated binary operand
//   bcd        : typed digits, most recent digit in [3:0]
//   ndigits    : digits accepted so far
//   done       : high while an entry is committed
//   valid      : one-cycle pulse on commit
//   err        : high in the error state (overflow or too many digits)
//   bad_digit  : one-cycle pulse on a press carrying a digit above 9
// Event priority: clear > commit > press.
module bcd_entry
  import bcd_entry_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              digit,
  input  logic                    push_n,
  input  logic                    commit,
  input  logic                    clear,
  output logic [WIDTH-1:0]        value,
  output logic [4*MAX_DIGITS-1:0] bcd,
  output logic [2:0]              ndigits,
  output logic                    done,
  output logic                    valid,
  output logic                    err,
  output logic                    bad_digit
);

  localparam logic [WIDTH+3:0] VALUE_MAX = {4'b0000, {WIDTH{1'b1}}};

  state_t           state;
  logic             press;
  logic             digit_ok;
  logic             full;
  logic             overflow;
  logic [WIDTH+3:0] value_ext;
  logic [WIDTH+3:0] next_value;

  push_sync u_push_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_n (push_n),
    .press  (press)
  );

  // value*10 as two shifts, with 4 guard bits so overflow is visible
  assign value_ext  = {4'b0000, value};
  assign next_value = (value_ext << 3) + (value_ext << 1) + (WIDTH+4)'(digit);
  assign digit_ok   = (digit <= DIGIT_MAX);
  assign full       = (ndigits == 3'(MAX_DIGITS));
  assign overflow   = (next_value > VALUE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      value     <= '0;
      bcd       <= '0;
      ndigits   <= '0;
      done      <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      valid     <= 1'b0;
      bad_digit <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        value   <= '0;
        bcd     <= '0;
        ndigits <= '0;
        done    <= 1'b0;
        err     <= 1'b0;
      end else if (commit) begin
        // DONE and ERROR ignore commit; a coinciding press is dropped
        if (state == IDLE || state == ENTRY) begin
          state <= DONE;
          done  <= 1'b1;
          valid <= 1'b1;
        end
      end else if (press) begin
        if (!digit_ok) begin
          bad_digit <= 1'b1;
        end else begin
          unique case (state)
            IDLE, DONE: begin
              state   <= ENTRY;
              value   <= WIDTH'(digit);
              bcd     <= (4*MAX_DIGITS)'(digit);
              ndigits <= 3'd1;
              done    <= 1'b0;
            end
            ENTRY: begin
              if (full || overflow) begin
                state <= ERROR;
                err   <= 1'b1;
              end else begin
                value   <= next_value[WIDTH-1:0];
                bcd     <= {bcd[4*MAX_DIGITS-5:0], digit};
                ndigits <= ndigits + 3'd1;
              end
            end
            ERROR: ;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_entry.sv
module tb_bcd_entry;

  localparam int EV_VALID = 0;
  localparam int EV_ERR   = 1;
  localparam int EV_BAD   = 2;

  typedef struct {
    int          kind;
    logic [17:0] v;
    logic [23:0] b;
    logic [2:0]  n;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  digit;
  logic        push_n;
  logic        commit;
  logic        clear;
  logic [17:0] value;
  logic [23:0] bcd;
  logic [2:0]  ndigits;
  logic        done;
  logic        valid;
  logic        err;
  logic        bad_digit;

  int  checks   = 0;
  int  failures = 0;
  ev_t q[$];

  bcd_entry #(.WIDTH(18), .MAX_DIGITS(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit     (digit),
    .push_n    (push_n),
    .commit    (commit),
    .clear     (clear),
    .value     (value),
    .bcd       (bcd),
    .ndigits   (ndigits),
    .done      (done),
    .valid     (valid),
    .err       (err),
    .bad_digit (bad_digit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [17:0] v, input logic [23:0] b,
                           input logic [2:0] n);
    ev_t e;
    e.kind = kind; e.v = v; e.b = b; e.n = n;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT reports an event
  logic err_prev = 1'b0;
  task automatic pop_cmp(input int kind, input string name);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected event, got value %0d expected none", name, value);
    end else begin
      e = q.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check({name, "_value"}, 32'(value), 32'(e.v));
      check({name, "_bcd"}, 32'(bcd), 32'(e.b));
      check({name, "_ndigits"}, 32'(ndigits), 32'(e.n));
      if (kind == EV_VALID) check({name, "_done"}, 32'(done), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (valid)            pop_cmp(EV_VALID, "sb_valid");
    if (bad_digit)        pop_cmp(EV_BAD, "sb_bad");
    if (err && !err_prev) pop_cmp(EV_ERR, "sb_err");
    err_prev <= err;
  end

  // Press with the button held for 'hold' cycles; returns bad_digit pulse count
  task automatic press(input logic [3:0] d, input int hold, output int nbad);
    nbad = 0;
    @(negedge clk);
    digit  = d;
    push_n = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      nbad += int'(bad_digit);
    end
    push_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      nbad += int'(bad_digit);
    end
  endtask

  task automatic press_seq(input logic [3:0] d);
    int nb;
    press(d, 4, nb);
  endtask

  // Press that checks value is unchanged after edges 1,2 and updated after edge 3
  task automatic press_timed(input logic [3:0] d, input logic [17:0] old_v,
                             input logic [17:0] new_v);
    @(negedge clk);
    digit  = d;
    push_n = 1'b0;
    @(posedge clk); #1 check("timing_edge1", 32'(value), 32'(old_v));
    @(posedge clk); #1 check("timing_edge2", 32'(value), 32'(old_v));
    @(posedge clk); #1 check("timing_edge3", 32'(value), 32'(new_v));
    @(negedge clk);
    push_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_commit(output int nvalid);
    nvalid = 0;
    @(negedge clk);
    commit = 1'b1;
    repeat (4) begin
      @(negedge clk);
      commit = 1'b0;
      nvalid += int'(valid);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int nv, nb;
    rst_n  = 1'b0;
    digit  = 4'd0;
    push_n = 1'b1;
    commit = 1'b0;
    clear  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_value", 32'(value), 32'd0);
    check("reset_flags", {28'd0, done, valid, err, bad_digit}, 32'd0);
    check("reset_ndigits", 32'(ndigits), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 1,2,3 commit
    press_timed(4'd1, 18'd0, 18'd1);
    press_timed(4'd2, 18'd1, 18'd12);
    press_timed(4'd3, 18'd12, 18'd123);
    expect_ev(EV_VALID, 18'd123, 24'h000123, 3'd3);
    do_commit(nv);
    check("t1_valid_width", 32'(nv), 32'd1);
    check("t1_done", 32'(done), 32'd1);
    do_clear();

    // 2: exact maximum, then overflow
    press_seq(4'd2); press_seq(4'd6); press_seq(4'd2);
    press_seq(4'd1); press_seq(4'd4); press_seq(4'd3);
    expect_ev(EV_VALID, 18'd262143, 24'h262143, 3'd6);
    do_commit(nv);
    check("t2_max_valid", 32'(nv), 32'd1);
    check("t2_max_err", 32'(err), 32'd0);
    do_clear();
    press_seq(4'd2); press_seq(4'd6); press_seq(4'd2);
    press_seq(4'd1); press_seq(4'd4);
    expect_ev(EV_ERR, 18'd26214, 24'h026214, 3'd5);
    press_seq(4'd4);
    do_commit(nv);
    check("t2_commit_in_err", 32'(nv), 32'd0);
    check("t2_err_held", {30'd0, err, done}, 32'h2);
    do_clear();
    check("t2_clear_value", 32'(value), 32'd0);
    check("t2_clear_bcd", 32'(bcd), 32'd0);
    check("t2_clear_flags", {29'd0, err, done, ndigits == 3'd0}, 32'd1);

    // 3: digit limit with leading zeros
    repeat (5) press_seq(4'd0);
    press_seq(4'd1);
    expect_ev(EV_ERR, 18'd1, 24'h000001, 3'd6);
    press_seq(4'd2);
    check("t3_value", 32'(value), 32'd1);
    check("t3_ndigits", 32'(ndigits), 32'd6);
    do_clear();

    // 4: invalid digit in ENTRY holding 45
    press_seq(4'd4); press_seq(4'd5);
    expect_ev(EV_BAD, 18'd45, 24'h000045, 3'd2);
    press(4'hA, 4, nb);
    check("t4_bad_pulses", 32'(nb), 32'd1);
    check("t4_value", 32'(value), 32'd45);
    check("t4_ndigits", 32'(ndigits), 32'd2);
    do_clear();

    // 5: clear + commit coincide with a press while holding 7
    press_seq(4'd7);
    check("t5_pre", 32'(value), 32'd7);
    nv = 0;
    @(negedge clk); digit = 4'd3; push_n = 1'b0;
    @(negedge clk);
    @(negedge clk); commit = 1'b1; clear = 1'b1;
    @(negedge clk); commit = 1'b0; clear = 1'b0; nv += int'(valid);
    repeat (4) begin @(negedge clk); nv += int'(valid); end
    push_n = 1'b1;
    repeat (4) begin @(negedge clk); nv += int'(valid); end
    check("t5_valid_never", 32'(nv), 32'd0);
    check("t5_value", 32'(value), 32'd0);
    check("t5_idle", {29'd0, done, err, ndigits == 3'd0}, 32'd1);

    // 6: asynchronous reset mid-entry, then a long hold accepts one digit
    press_seq(4'd9); press_seq(4'd8);
    check("t6_pre", 32'(value), 32'd98);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("t6_async_value", 32'(value), 32'd0);
    check("t6_async_bcd", 32'(bcd), 32'd0);
    check("t6_async_ndigits", 32'(ndigits), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    press(4'd4, 20, nb);
    check("t6_hold_value", 32'(value), 32'd4);
    check("t6_hold_ndigits", 32'(ndigits), 32'd1);
    expect_ev(EV_VALID, 18'd4, 24'h000004, 3'd1);
    do_commit(nv);
    check("t6_valid", 32'(nv), 32'd1);

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    while (q.size() != 0) begin
      ev_t e;
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL sb_missing: got no event expected kind %0d value %0d", e.kind, e.v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_entry.md
Name: bcd_entry

Overview:
Decimal operand-entry block: the input-side counterpart of the binary-to-BCD display path. The operator keys one BCD digit at a time on SW[3:0] and presses a pushbutton for each digit. The block accumulates the digits into a binary operand (value = value*10 + digit) and mirrors the typed digits as packed BCD so the existing segdec display chain can echo them. It sits between the board switches/keys and the calculator's operand registers. It replaces raw 9-bit switch capture with full 0..262143 decimal entry.

Parameters:
WIDTH, 18, binary operand width; maximum accepted value is 2^WIDTH-1.
MAX_DIGITS, 6, maximum number of digits per entry, including leading zeros.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
digit  in  4  BCD digit from SW[3:0]; sampled when a press is detected
push_n  in  1  raw active-low digit pushbutton, asynchronous to clk
commit  in  1  synchronous single-cycle pulse; ends the entry
clear  in  1  synchronous single-cycle pulse; abandons the entry
value  out  WIDTH  accumulated binary operand
bcd  out  4*MAX_DIGITS  typed digits, packed; last digit in [3:0]
ndigits  out  3  number of digits accepted so far
done  out  1  level; high while an entry is committed
valid  out  1  one-cycle pulse on commit
err  out  1  level; high in ERROR state
bad_digit  out  1  one-cycle pulse when a press carries a digit greater than 9

Behaviour:
- Reset (asynchronous, takes effect any time, including mid-entry):
  - state = IDLE
  - value, bcd, ndigits = 0
  - done, valid, err, bad_digit = 0
  - synchronizer flops = 1
- Press detection:
  - push_n passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - press = s3 & ~s2.
  - The accumulate happens at the 3rd rising clk edge after push_n is first sampled low.
  - Exactly one press per falling edge; holding the button does not repeat.
  - Debouncing is external.
- States:
  - IDLE: press with digit ≤ 9 → ENTRY; value = digit, ndigits = 1, bcd = digit. Commit → DONE with value 0 and valid pulse.
  - ENTRY: press with digit ≤ 9:
    - next = value*10 + digit, computed as (v<<3)+(v<<1)+digit at width WIDTH+4.
    - If ndigits == MAX_DIGITS or next > 2^WIDTH-1 → ERROR; value, bcd and ndigits hold their old contents.
    - Otherwise value = next[WIDTH-1:0], bcd = {bcd shifted left 4, digit}, ndigits += 1.
    - Commit → DONE with valid pulse.
  - DONE: done = 1 and value is held stable for the consumer. A press with digit ≤ 9 starts a new entry (value = digit, ndigits = 1, bcd = digit, state ENTRY, done = 0). Commit is ignored.
  - ERROR: err = 1; presses and commit are ignored; only clear exits.
- Invalid digit (digit > 9) on a press: bad_digit pulses for one cycle; no state, value, bcd or ndigits change, in any state.
- Clear, from any state: → IDLE; value, bcd, ndigits = 0; done = err = 0.
- Simultaneous events, priority order: clear > commit > press. A press coinciding with commit or clear is discarded.
- Leading zeros count as digits, e.g. "0,0,7" gives value 7, ndigits 3, bcd 0x007.
- All outputs are registered; none is combinational from the inputs.

Decomposition:
- Shared package: the state enum (IDLE, ENTRY, DONE, ERROR), the MAX_DIGITS/WIDTH defaults, and the constant DIGIT_MAX = 9.
- One sub-module, push_sync: a 2-flop synchronizer plus falling-edge detector that outputs a one-cycle press. It is reusable for key0 and other buttons.
- The accumulator and FSM stay in bcd_entry.

Test Plan:
1. Presses 1,2,3 then commit → value = 123, bcd = 0x000123, ndigits = 3, valid high exactly 1 cycle, done = 1; each value update occurs 3 edges after push_n falls.
2. Presses 2,6,2,1,4,3 then commit → value = 262143, no err. Repeat with 2,6,2,1,4,4 → err = 1 after the 6th press; value = 26214, ndigits = 5, bcd = 0x026214; commit ignored; clear → IDLE, all zero.
3. Presses 0,0,0,0,0,1 then a 7th press with 2 → err = 1 via the digit limit; value stays 1 and ndigits = 6.
4. Press with digit = 0xA in ENTRY holding 45 → bad_digit pulses 1 cycle; value stays 45, ndigits stays 2.
5. clear and commit asserted in the same cycle as a press, in ENTRY holding 7 → IDLE, value = 0, valid never asserted.
6. rst_n asserted low between clock edges mid-entry (value 98) → outputs zero immediately, without waiting for clk. After release, hold push_n low for 20 cycles → exactly one digit is accepted.
